// File: rtl/trng_responder.sv
// trng_responder: responder side of the ChaCha20 core's TRNG handshake.
// Samples a synchronised raw noise bit every SAMPLE_DIV cycles. Von Neumann
// pairs are debiased, the resulting bits are packed MSB-first into 32-bit
// words, and the words are buffered in a small FIFO. Each request takes one
// word. A repetition-count health test drops the block into FAIL when the
// source sticks. FAIL flushes everything and blocks delivery until clear_fail.
module trng_responder #(
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int SAMPLE_DIV = 4,   // >= 1
  parameter int REP_LIMIT  = 32   // >= 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          raw_bit,
  input  logic                          clear_fail,
  input  logic                          trng_request,
  output logic [31:0]                   trng_data,
  output logic                          trng_ready,
  output logic                          health_fail,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX    = REP_W'(REP_LIMIT);
  localparam logic [LVL_W-1:0] LEVEL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STARTUP,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t             state;

  // Raw-bit synchroniser
  logic               sync_q1;
  logic               sync_q2;

  // Sampling and health test
  logic [DIV_W-1:0]   div_cnt;
  logic               sample_tick;
  logic [REP_W-1:0]   rep_cnt;
  logic               prev_sample;
  logic               rep_tripped;
  logic               fail_now;

  // Debias and packing
  logic               collecting;
  logic               pair_full;
  logic               pair_bit;
  logic               debias_valid;
  logic [30:0]        shreg;        // bit 31 of a word is never needed after it completes
  logic [4:0]         bit_cnt;
  logic [31:0]        word_value;
  logic               word_done;

  // FIFO
  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  assign sample_tick = enable && (div_cnt == DIV_LAST);
  assign rep_tripped = (rep_cnt == REP_MAX);

  // A trip is acted on in the same edge that enters FAIL, so nothing is pushed
  // or delivered in the cycle the health test fires.
  assign fail_now    = (state == ST_FAIL) || rep_tripped;

  assign collecting   = enable && !fail_now &&
                        ((state == ST_STARTUP) || (state == ST_RUN));

  // The stored first sample of an unequal pair is the debiased bit (10->1, 01->0).
  assign debias_valid = collecting && sample_tick && pair_full && (pair_bit != sync_q2);
  assign word_value   = {shreg, pair_bit};
  assign word_done    = debias_valid && (bit_cnt == 5'd31);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == LEVEL_FULL);

  // A pop is only taken when no ready is showing, which spaces words two cycles apart.
  assign pop  = !fail_now && ((state == ST_RUN) || (state == ST_IDLE)) &&
                trng_request && !fifo_empty && !trng_ready;
  // When full, a word can still enter if the head leaves in the same edge.
  assign push = (state == ST_RUN) && word_done && (!fifo_full || pop);

  assign fifo_level = count;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous noise source
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments so that every
    // flop samples pre-edge values regardless of statement order.
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw_bit;
      sync_q2 <= sync_q1;
    end
  end

  // Sample divider: free-runs 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (!enable || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Repetition-count health test on every sample, saturating at REP_LIMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt     <= '0;
      prev_sample <= 1'b0;
    end else if ((state == ST_FAIL) && clear_fail) begin
      rep_cnt     <= '0;
    end else if (sample_tick) begin
      prev_sample <= sync_q2;
      // A zero count means no reference sample yet, so the run starts afresh.
      if ((rep_cnt != '0) && (sync_q2 == prev_sample)) begin
        if (!rep_tripped) begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        rep_cnt <= REP_W'(1);
      end
    end
  end

  // Von Neumann pairing and word packing; partial state is dropped outside collection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_full <= 1'b0;
      pair_bit  <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else if (!collecting) begin
      pair_full <= 1'b0;
      pair_bit  <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      if (sample_tick) begin
        if (!pair_full) begin
          pair_full <= 1'b1;
          pair_bit  <= sync_q2;
        end else begin
          pair_full <= 1'b0;
        end
      end
      // bit_cnt wraps 31 -> 0 on a completed word, so the next word starts clean
      // whether or not this one was kept.
      if (debias_valid) begin
        shreg   <= word_value[30:0];
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Control FSM with registered health_fail; a health trip overrides every other state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      health_fail <= 1'b0;
    end else if ((state != ST_FAIL) && rep_tripped) begin
      state       <= ST_FAIL;
      health_fail <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_STARTUP;
          end
        end
        ST_STARTUP: begin
          // The first completed word only warms the conditioner up and is discarded.
          if (!enable) begin
            state <= ST_IDLE;
          end else if (word_done) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            state <= ST_IDLE;
          end
        end
        ST_FAIL: begin
          if (clear_fail) begin
            state       <= ST_STARTUP;
            health_fail <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          health_fail <= 1'b0;
        end
      endcase
    end
  end

  // Word FIFO: circular buffer with occupancy count, flushed while failing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is cleared on reset too, so no stale entropy
      // survives a reset; this costs a reset net on each storage flop.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fail_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word_value;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Delivery: one-cycle ready pulse carrying the popped head, data zero otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trng_ready <= 1'b0;
      trng_data  <= '0;
    end else begin
      trng_ready <= pop;
      trng_data  <= pop ? mem[rd_ptr] : '0;
    end
  end

endmodule
